// File: rtl/ma_pkg.sv
// Shared encodings for the memory-access stage: op/len codes, FSM states
// and the access-size helper used by both the top and the lane aligner.
package ma_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_STORE = 2'b01,
        OP_LOADS = 2'b10,
        OP_LOADU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        LEN_B = 2'b00,
        LEN_H = 2'b01,
        LEN_W = 2'b10,
        LEN_D = 2'b11
    } len_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_HOLD = 2'b10
    } state_e;

    // A double-word request on a 32-bit datapath degrades to a word access.
    function automatic int size_bytes(input logic [1:0] len, input int data_l);
        case (len)
            LEN_B:   return 1;
            LEN_H:   return 2;
            LEN_W:   return 4;
            default: return (data_l == 64) ? 8 : 4;
        endcase
    endfunction

endpackage

// File: rtl/ma_lane_align.sv
// Combinational byte-lane steering: store data/strobe placement with
// misalignment detection, and load lane extraction with sign/zero extension.
module ma_lane_align
    import ma_pkg::*;
#(
    parameter  int DATA_L = 32,
    localparam int STRB_L = DATA_L / 8,
    localparam int OFF_W  = $clog2(STRB_L)
) (
    input  logic [1:0]        st_len_i,
    input  logic [OFF_W-1:0]  st_off_i,
    input  logic [DATA_L-1:0] st_data_i,
    output logic [DATA_L-1:0] st_wdata_o,
    output logic [STRB_L-1:0] st_wstrb_o,
    output logic              st_misalign_o,
    input  logic [1:0]        ld_len_i,
    input  logic              ld_signed_i,
    input  logic [OFF_W-1:0]  ld_off_i,
    input  logic [DATA_L-1:0] ld_rdata_i,
    output logic [DATA_L-1:0] ld_val_o
);

    int                st_size;
    int                ld_size;
    logic [DATA_L-1:0] st_mask;
    logic [STRB_L-1:0] st_bytes;
    logic [DATA_L-1:0] ld_lane;
    logic              ld_msb;
    logic              ld_ext;

    assign st_size = size_bytes(st_len_i, DATA_L);
    assign ld_size = size_bytes(ld_len_i, DATA_L);

    genvar gi;
    generate
        for (gi = 0; gi < STRB_L; gi++) begin : g_lane
            assign st_mask[gi*8 +: 8] = (gi < st_size) ? 8'hFF : 8'h00;
            assign st_bytes[gi]       = (gi < st_size);
            assign ld_val_o[gi*8 +: 8] = (gi < ld_size) ? ld_lane[gi*8 +: 8] : {8{ld_ext}};
        end
    endgenerate

    // Sizes are powers of two no wider than the bus, so the offset bits alone decide alignment.
    assign st_misalign_o = (st_off_i & OFF_W'(st_size - 1)) != '0;
    assign st_wdata_o    = (st_data_i & st_mask) << {st_off_i, 3'b000};
    assign st_wstrb_o    = st_bytes << st_off_i;

    assign ld_lane = ld_rdata_i >> {ld_off_i, 3'b000};

    always_comb begin
        case (ld_size)
            1:       ld_msb = ld_lane[7];
            2:       ld_msb = ld_lane[15];
            4:       ld_msb = ld_lane[31];
            default: ld_msb = ld_lane[DATA_L-1];
        endcase
    end

    assign ld_ext = ld_signed_i & ld_msb;

endmodule

// File: rtl/ma_stage.sv
// Memory-access pipeline stage: takes one EX result per handshake, runs at most
// one memory transaction, and presents a registered result to WB.
module ma_stage
    import ma_pkg::*;
#(
    parameter int DATA_L = 32,
    parameter int ADDR_L = 32,
    parameter int IDX_L  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [1:0]          in_len,
    input  logic [ADDR_L-1:0]   in_addr,
    input  logic [DATA_L-1:0]   in_data,
    input  logic                in_wb_e,
    input  logic [IDX_L-1:0]    in_wb_idx,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_L-1:0]   mem_addr,
    output logic [DATA_L-1:0]   mem_wdata,
    output logic [DATA_L/8-1:0] mem_wstrb,
    input  logic [DATA_L-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                wb_e,
    output logic [IDX_L-1:0]    wb_idx,
    output logic [DATA_L-1:0]   wb_out,
    output logic                exc_align,
    output logic [IDX_L-1:0]    fwd_idx,
    output logic [DATA_L-1:0]   fwd_val,
    output logic                ld_pend,
    output logic [IDX_L-1:0]    ld_pend_idx
);

    localparam int STRB_L = DATA_L / 8;
    localparam int OFF_W  = $clog2(STRB_L);

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [1:0]          len_q, len_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic                wb_e_q, wb_e_d;
    logic [IDX_L-1:0]    wb_idx_q, wb_idx_d;
    logic [DATA_L-1:0]   wb_out_q, wb_out_d;
    logic                exc_q, exc_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_L-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_L-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_L-1:0]   mem_wstrb_q, mem_wstrb_d;

    logic                xfer;
    logic [DATA_L-1:0]   st_wdata;
    logic [STRB_L-1:0]   st_wstrb;
    logic                st_misalign;
    logic [DATA_L-1:0]   ld_val;

    assign in_ready = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
    assign xfer     = in_valid && in_ready;

    // Store path sees the incoming transfer; load path sees the latched request.
    ma_lane_align #(
        .DATA_L(DATA_L)
    ) u_align (
        .st_len_i     (in_len),
        .st_off_i     (in_addr[OFF_W-1:0]),
        .st_data_i    (in_data),
        .st_wdata_o   (st_wdata),
        .st_wstrb_o   (st_wstrb),
        .st_misalign_o(st_misalign),
        .ld_len_i     (len_q),
        .ld_signed_i  (op_q == OP_LOADS),
        .ld_off_i     (off_q),
        .ld_rdata_i   (mem_rdata),
        .ld_val_o     (ld_val)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        len_d       = len_q;
        off_d       = off_q;
        wb_e_d      = wb_e_q;
        wb_idx_d    = wb_idx_q;
        wb_out_d    = wb_out_q;
        exc_d       = exc_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;

        case (state_q)
            S_REQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = S_HOLD;
                    if (mem_we_q) begin
                        wb_e_d = 1'b0;
                    end else begin
                        wb_out_d = ld_val;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        // A transfer in HOLD overrides the return to IDLE, giving back-to-back throughput.
        if (xfer) begin
            op_d      = in_op;
            len_d     = in_len;
            off_d     = in_addr[OFF_W-1:0];
            wb_idx_d  = in_wb_idx;
            wb_e_d    = in_wb_e;
            wb_out_d  = '0;
            exc_d     = 1'b0;
            mem_req_d = 1'b0;
            if (in_op == OP_NONE) begin
                wb_out_d = DATA_L'(in_addr);
                state_d  = S_HOLD;
            end else if (st_misalign) begin
                wb_e_d  = 1'b0;
                exc_d   = 1'b1;
                state_d = S_HOLD;
            end else begin
                mem_req_d   = 1'b1;
                mem_we_d    = (in_op == OP_STORE);
                mem_addr_d  = {in_addr[ADDR_L-1:OFF_W], {OFF_W{1'b0}}};
                mem_wdata_d = (in_op == OP_STORE) ? st_wdata : '0;
                mem_wstrb_d = (in_op == OP_STORE) ? st_wstrb : '0;
                state_d     = S_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            len_q       <= '0;
            off_q       <= '0;
            wb_e_q      <= 1'b0;
            wb_idx_q    <= '0;
            wb_out_q    <= '0;
            exc_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            len_q       <= len_d;
            off_q       <= off_d;
            wb_e_q      <= wb_e_d;
            wb_idx_q    <= wb_idx_d;
            wb_out_q    <= wb_out_d;
            exc_q       <= exc_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wstrb   = mem_wstrb_q;
    assign out_valid   = (state_q == S_HOLD);
    assign wb_e        = wb_e_q;
    assign wb_idx      = wb_idx_q;
    assign wb_out      = wb_out_q;
    assign exc_align   = exc_q;
    assign fwd_idx     = (out_valid && wb_e_q) ? wb_idx_q : '0;
    assign fwd_val     = wb_out_q;
    assign ld_pend     = (state_q == S_REQ) && !mem_we_q;
    assign ld_pend_idx = ld_pend ? wb_idx_q : '0;

endmodule

// File: tb/tb_ma_stage.sv
// Directed bench for ma_stage: a vector table of single transactions on a
// 32-bit instance plus hand sequences for back-pressure, reset-in-REQ and 64-bit lanes.
module tb_ma_stage;
    import ma_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready;
    logic [1:0]  in_op, in_len;
    logic [31:0] in_addr, in_data;
    logic        in_wb_e;
    logic [4:0]  in_wb_idx;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic        out_valid, out_ready;
    logic        wb_e;
    logic [4:0]  wb_idx;
    logic [31:0] wb_out;
    logic        exc_align;
    logic [4:0]  fwd_idx;
    logic [31:0] fwd_val;
    logic        ld_pend;
    logic [4:0]  ld_pend_idx;

    ma_stage #(.DATA_L(32), .ADDR_L(32), .IDX_L(5)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_len(in_len),
        .in_addr(in_addr), .in_data(in_data), .in_wb_e(in_wb_e), .in_wb_idx(in_wb_idx),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .out_valid(out_valid), .out_ready(out_ready), .wb_e(wb_e), .wb_idx(wb_idx),
        .wb_out(wb_out), .exc_align(exc_align), .fwd_idx(fwd_idx), .fwd_val(fwd_val),
        .ld_pend(ld_pend), .ld_pend_idx(ld_pend_idx)
    );

    logic        d_in_valid, d_in_ready;
    logic [1:0]  d_in_op, d_in_len;
    logic [31:0] d_in_addr;
    logic [63:0] d_in_data;
    logic        d_in_wb_e;
    logic [4:0]  d_in_wb_idx;
    logic        d_mem_req, d_mem_we;
    logic [31:0] d_mem_addr;
    logic [63:0] d_mem_wdata, d_mem_rdata;
    logic [7:0]  d_mem_wstrb;
    logic        d_mem_ack;
    logic        d_out_valid, d_out_ready;
    logic        d_wb_e;
    logic [4:0]  d_wb_idx;
    logic [63:0] d_wb_out;
    logic        d_exc_align;
    logic [4:0]  d_fwd_idx;
    logic [63:0] d_fwd_val;
    logic        d_ld_pend;
    logic [4:0]  d_ld_pend_idx;

    ma_stage #(.DATA_L(64), .ADDR_L(32), .IDX_L(5)) u_dut64 (
        .clk(clk), .rst(rst),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_op(d_in_op), .in_len(d_in_len),
        .in_addr(d_in_addr), .in_data(d_in_data), .in_wb_e(d_in_wb_e), .in_wb_idx(d_in_wb_idx),
        .mem_req(d_mem_req), .mem_we(d_mem_we), .mem_addr(d_mem_addr), .mem_wdata(d_mem_wdata),
        .mem_wstrb(d_mem_wstrb), .mem_rdata(d_mem_rdata), .mem_ack(d_mem_ack),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .wb_e(d_wb_e), .wb_idx(d_wb_idx),
        .wb_out(d_wb_out), .exc_align(d_exc_align), .fwd_idx(d_fwd_idx), .fwd_val(d_fwd_val),
        .ld_pend(d_ld_pend), .ld_pend_idx(d_ld_pend_idx)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] data;
        logic        wb_e;
        logic [4:0]  idx;
        logic [31:0] rdata;
        int          nreq;     // request cycles before ack; 0 = no memory access expected
        logic [31:0] e_maddr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        logic        e_wb_e;
        logic        chk_out;
        logic [31:0] e_out;
        logic        e_exc;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    task automatic run_vec(input vec_t v, input int n);
        in_op     = v.op;
        in_len    = v.len;
        in_addr   = v.addr;
        in_data   = v.data;
        in_wb_e   = v.wb_e;
        in_wb_idx = v.idx;
        in_valid  = 1'b1;
        #1;
        chk($sformatf("v%0d_in_ready", n), in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (v.nreq > 0) begin
            for (int k = 1; k <= v.nreq; k++) begin
                chk($sformatf("v%0d_mem_req_c%0d", n, k), mem_req, 1);
                chk($sformatf("v%0d_mem_we", n), mem_we, v.op == OP_STORE);
                chk($sformatf("v%0d_mem_addr", n), mem_addr, v.e_maddr);
                chk($sformatf("v%0d_out_valid_req", n), out_valid, 0);
                chk($sformatf("v%0d_ld_pend", n), ld_pend, v.op != OP_STORE);
                if (v.op == OP_STORE) begin
                    chk($sformatf("v%0d_mem_wdata", n), mem_wdata, v.e_wdata);
                    chk($sformatf("v%0d_mem_wstrb", n), mem_wstrb, v.e_wstrb);
                end else begin
                    chk($sformatf("v%0d_ld_pend_idx", n), ld_pend_idx, v.idx);
                end
                if (k == v.nreq) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rdata;
                end
                @(posedge clk); #1;
                mem_ack   = 1'b0;
                mem_rdata = '0;
            end
        end
        chk($sformatf("v%0d_mem_req_hold", n), mem_req, 0);
        chk($sformatf("v%0d_out_valid", n), out_valid, 1);
        chk($sformatf("v%0d_wb_e", n), wb_e, v.e_wb_e);
        chk($sformatf("v%0d_wb_idx", n), wb_idx, v.idx);
        chk($sformatf("v%0d_exc_align", n), exc_align, v.e_exc);
        chk($sformatf("v%0d_fwd_idx", n), fwd_idx, v.e_wb_e ? v.idx : 5'd0);
        chk($sformatf("v%0d_ld_pend_hold", n), ld_pend, 0);
        if (v.chk_out) begin
            chk($sformatf("v%0d_wb_out", n), wb_out, v.e_out);
            chk($sformatf("v%0d_fwd_val", n), fwd_val, v.e_out);
        end
        @(posedge clk); #1;
        chk($sformatf("v%0d_out_valid_idle", n), out_valid, 0);
        chk($sformatf("v%0d_in_ready_idle", n), in_ready, 1);
    endtask

    task automatic run64(input string name, input logic [1:0] op, input logic [1:0] len,
                         input logic [31:0] addr, input logic [63:0] data, input logic [63:0] rdata,
                         input logic [31:0] e_maddr, input logic [63:0] e_wdata,
                         input logic [7:0] e_wstrb, input logic [63:0] e_out);
        d_in_op     = op;
        d_in_len    = len;
        d_in_addr   = addr;
        d_in_data   = data;
        d_in_wb_e   = 1'b1;
        d_in_wb_idx = 5'd10;
        d_in_valid  = 1'b1;
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        chk({name, "_mem_req"}, d_mem_req, 1);
        chk({name, "_mem_addr"}, d_mem_addr, e_maddr);
        if (op == OP_STORE) begin
            chk({name, "_mem_wdata"}, d_mem_wdata, e_wdata);
            chk({name, "_mem_wstrb"}, d_mem_wstrb, e_wstrb);
        end
        d_mem_ack   = 1'b1;
        d_mem_rdata = rdata;
        @(posedge clk); #1;
        d_mem_ack   = 1'b0;
        d_mem_rdata = '0;
        chk({name, "_out_valid"}, d_out_valid, 1);
        chk({name, "_wb_e"}, d_wb_e, op != OP_STORE);
        if (op != OP_STORE) chk({name, "_wb_out"}, d_wb_out, e_out);
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0]  = '{OP_NONE,  LEN_W, 32'h1234,     32'h0,        1'b1, 5'd5,  32'h0,        0, 32'h0,   32'h0,        4'b0000, 1'b1, 1'b1, 32'h00001234, 1'b0};
        vecs[1]  = '{OP_LOADS, LEN_B, 32'h103,      32'h0,        1'b1, 5'd7,  32'h80FF1234, 3, 32'h100, 32'h0,        4'b0000, 1'b1, 1'b1, 32'hFFFFFF80, 1'b0};
        vecs[2]  = '{OP_LOADU, LEN_H, 32'h102,      32'h0,        1'b1, 5'd9,  32'h80FF1234, 1, 32'h100, 32'h0,        4'b0000, 1'b1, 1'b1, 32'h000080FF, 1'b0};
        vecs[3]  = '{OP_STORE, LEN_B, 32'h101,      32'h123456AB, 1'b1, 5'd11, 32'h0,        2, 32'h100, 32'h0000AB00, 4'b0010, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[4]  = '{OP_LOADS, LEN_W, 32'h102,      32'h0,        1'b1, 5'd12, 32'h0,        0, 32'h0,   32'h0,        4'b0000, 1'b0, 1'b0, 32'h0,        1'b1};
        vecs[5]  = '{OP_LOADS, LEN_H, 32'h102,      32'h0,        1'b1, 5'd13, 32'h80FF1234, 1, 32'h100, 32'h0,        4'b0000, 1'b1, 1'b1, 32'hFFFF80FF, 1'b0};
        vecs[6]  = '{OP_LOADU, LEN_B, 32'h101,      32'h0,        1'b1, 5'd14, 32'h80FF1234, 2, 32'h100, 32'h0,        4'b0000, 1'b1, 1'b1, 32'h00000012, 1'b0};
        vecs[7]  = '{OP_LOADS, LEN_W, 32'h200,      32'h0,        1'b1, 5'd15, 32'h80FF1234, 1, 32'h200, 32'h0,        4'b0000, 1'b1, 1'b1, 32'h80FF1234, 1'b0};
        vecs[8]  = '{OP_STORE, LEN_H, 32'h102,      32'h0000BEEF, 1'b1, 5'd16, 32'h0,        1, 32'h100, 32'hBEEF0000, 4'b1100, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[9]  = '{OP_STORE, LEN_W, 32'h4,        32'hDEADBEEF, 1'b0, 5'd17, 32'h0,        1, 32'h4,   32'hDEADBEEF, 4'b1111, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[10] = '{OP_STORE, LEN_H, 32'h101,      32'h0000FFFF, 1'b1, 5'd18, 32'h0,        0, 32'h0,   32'h0,        4'b0000, 1'b0, 1'b0, 32'h0,        1'b1};
        vecs[11] = '{OP_LOADU, LEN_D, 32'h8,        32'h0,        1'b1, 5'd19, 32'h80000001, 1, 32'h8,   32'h0,        4'b0000, 1'b1, 1'b1, 32'h80000001, 1'b0};
        vecs[12] = '{OP_NONE,  LEN_B, 32'hFFFFFFFF, 32'h0,        1'b0, 5'd3,  32'h0,        0, 32'h0,   32'h0,        4'b0000, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0};
        vecs[13] = '{OP_LOADS, LEN_B, 32'h102,      32'h0,        1'b1, 5'd20, 32'h80FF1234, 1, 32'h100, 32'h0,        4'b0000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0};
        vecs[14] = '{OP_LOADU, LEN_D, 32'h6,        32'h0,        1'b1, 5'd21, 32'h0,        0, 32'h0,   32'h0,        4'b0000, 1'b0, 1'b0, 32'h0,        1'b1};

        rst = 1'b1;
        in_valid = 1'b0; in_op = '0; in_len = '0; in_addr = '0; in_data = '0;
        in_wb_e = 1'b0; in_wb_idx = '0; mem_rdata = '0; mem_ack = 1'b0; out_ready = 1'b1;
        d_in_valid = 1'b0; d_in_op = '0; d_in_len = '0; d_in_addr = '0; d_in_data = '0;
        d_in_wb_e = 1'b0; d_in_wb_idx = '0; d_mem_rdata = '0; d_mem_ack = 1'b0; d_out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_wb_out", wb_out, 0);
        chk("rst_fwd_idx", fwd_idx, 0);
        chk("rst_ld_pend", ld_pend, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], i);
        end

        // Back-pressure: result held for 3 cycles while a second op waits.
        out_ready = 1'b0;
        in_op = OP_NONE; in_len = LEN_W; in_addr = 32'h55; in_wb_e = 1'b1; in_wb_idx = 5'd4;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_addr = 32'h66; in_wb_idx = 5'd6;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_out_valid_c%0d", k), out_valid, 1);
            chk($sformatf("bp_wb_out_c%0d", k), wb_out, 32'h55);
            chk($sformatf("bp_fwd_idx_c%0d", k), fwd_idx, 5'd4);
            chk($sformatf("bp_in_ready_c%0d", k), in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_b2b_out_valid", out_valid, 1);
        chk("bp_b2b_wb_out", wb_out, 32'h66);
        chk("bp_b2b_fwd_idx", fwd_idx, 5'd6);
        @(posedge clk); #1;
        chk("bp_idle_out_valid", out_valid, 0);

        // Reset while a load is outstanding, then a stray ack.
        in_op = OP_LOADS; in_len = LEN_W; in_addr = 32'h40; in_wb_e = 1'b1; in_wb_idx = 5'd8;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rr_mem_req_pre", mem_req, 1);
        chk("rr_ld_pend_pre", ld_pend, 1);
        chk("rr_ld_pend_idx_pre", ld_pend_idx, 5'd8);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rr_mem_req", mem_req, 0);
        chk("rr_mem_addr", mem_addr, 0);
        chk("rr_out_valid", out_valid, 0);
        chk("rr_wb_out", wb_out, 0);
        chk("rr_wb_idx", wb_idx, 0);
        chk("rr_wb_e", wb_e, 0);
        chk("rr_ld_pend", ld_pend, 0);
        chk("rr_ld_pend_idx", ld_pend_idx, 0);
        chk("rr_in_ready", in_ready, 1);
        mem_ack = 1'b1; mem_rdata = 32'h1111;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = '0;
        chk("rr_late_ack_out_valid", out_valid, 0);
        chk("rr_late_ack_mem_req", mem_req, 0);
        @(posedge clk); #1;
        chk("rr_late_ack_out_valid2", out_valid, 0);

        // 64-bit datapath lanes.
        run64("d64_dload", OP_LOADU, LEN_D, 32'h8, 64'h0, 64'h8000000000000001,
              32'h8, 64'h0, 8'h00, 64'h8000000000000001);
        run64("d64_wload", OP_LOADS, LEN_W, 32'hC, 64'h0, 64'h8000000000000000,
              32'h8, 64'h0, 8'h00, 64'hFFFFFFFF80000000);
        run64("d64_bstore", OP_STORE, LEN_B, 32'h5, 64'hAB, 64'h0,
              32'h0, 64'h0000AB0000000000, 8'h20, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ma_stage.md
# ma_stage

Parametrised memory-access (MA) pipeline stage sitting between EX and WB. It accepts one EX result per valid/ready handshake and performs any load or store through a single request/acknowledge memory port. Byte-lane alignment, load sign/zero extension and misalignment detection happen inside the stage. It presents a registered result to WB with its own valid/ready handshake, and drives forwarding and load-pending information back to ID.

## Interface
- DATA_L, 32, data/register width; legal values are 32 and 64.
- ADDR_L, 32, byte-address width.
- IDX_L, 5, register-index width.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  EX result valid.
- in_ready  out  1  stage can accept the EX result.
- in_op  in  2  operation: 00 none, 01 store, 10 load signed, 11 load unsigned.
- in_len  in  2  access size: 00 byte, 01 half, 10 word, 11 double. 11 is treated as word when DATA_L=32.
- in_addr  in  ADDR_L  ALU result, or effective byte address.
- in_data  in  DATA_L  store data.
- in_wb_e  in  1  result writes the register file.
- in_wb_idx  in  IDX_L  destination register.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_L  in_addr with the low log2(DATA_L/8) bits cleared.
- mem_wdata  out  DATA_L  store data shifted to its byte lane.
- mem_wstrb  out  DATA_L/8  byte-enable mask.
- mem_rdata  in  DATA_L  read data; valid in the cycle mem_ack=1.
- mem_ack  in  1  completion strobe; ignored unless mem_req=1.
- out_valid  out  1  WB result valid.
- out_ready  in  1  WB accepts the result.
- wb_e  out  1  register-file write enable.
- wb_idx  out  IDX_L  destination register.
- wb_out  out  DATA_L  result value.
- exc_align  out  1  result belongs to a misaligned access; qualified by out_valid.
- fwd_idx  out  IDX_L  forwarding index; 0 when there is nothing to forward.
- fwd_val  out  DATA_L  equals wb_out.
- ld_pend  out  1  a load is outstanding in state REQ.
- ld_pend_idx  out  IDX_L  destination register of that outstanding load.

## Operation
- The FSM has three states: IDLE, REQ and HOLD.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). A transfer occurs when in_valid && in_ready.
- Alignment rule: size in bytes is 1, 2, 4 or 8; the access is misaligned when in_addr mod size ≠ 0.
- On a transfer the stage latches op, len, addr, data, wb_e and wb_idx, then:
  - op=00: wb_out=in_addr zero-extended to DATA_L; wb_e=in_wb_e; next state HOLD.
  - Misaligned load or store: no memory request; wb_e=0; exc_align=1; next state HOLD.
  - Aligned load or store: mem_req=1; mem_we=(op==01); next state REQ.
- REQ state:
  - All mem_* outputs stay stable until mem_ack.
  - On mem_ack: mem_req=0.
  - For a load, lane = mem_rdata >> (8·offset), where offset = addr[log2(DATA_L/8)-1:0]. The low size·8 bits are sign-extended (op 10) or zero-extended (op 11) into wb_out; wb_e keeps its latched value.
  - For a store, wb_e=0.
  - Next state HOLD.
- Store lanes: mem_wdata = in_data[size·8-1:0] << (8·offset); mem_wstrb = ((1<<size)-1) << offset. Byte order is little-endian.
- HOLD state: out_valid=1 and all result outputs stay stable. On out_ready, go to IDLE, or capture a new transfer in the same cycle.
- Forwarding: fwd_idx = (out_valid && wb_e) ? wb_idx : 0.
- ld_pend = (state==REQ && !mem_we), with ld_pend_idx set to the latched wb_idx.

## Timing
- Reset values: state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0; out_valid=0, wb_e=0, wb_idx=0, wb_out=0; exc_align=0; fwd_idx=0; ld_pend=0, ld_pend_idx=0. in_ready=1 in the first cycle after reset.
- Non-memory and misaligned ops: out_valid rises the cycle after the transfer. Throughput is 1 per cycle while out_ready=1.
- Memory ops: mem_req rises the cycle after the transfer. mem_ack may arrive in the first request cycle or later. out_valid rises the cycle after mem_ack. Best case is 2 cycles from transfer to result.
- mem_ack with mem_req=0 is ignored. mem_ack and out_ready never interact, because states are exclusive.
- Reset wins over every other input. Reset in REQ abandons the access: mem_req=0 the next cycle, and any later mem_ack is ignored in IDLE.
- Back-pressure: while out_ready=0 the stage holds in HOLD with in_ready=0.

## Structure
- Package ma_pkg holds the op codes, len codes, the state enum IDLE/REQ/HOLD, and the size-in-bytes function.
- Sub-module ma_lane_align is combinational and instantiated once. It provides:
  - store path: (len, offset, data) → wdata, wstrb, misalign;
  - load path: (len, signed, offset, rdata) → wb value.

## Test plan
- ALU pass-through, DATA_L=32: op=00, addr=0x1234, wb_e=1, idx=5 → next cycle out_valid=1, wb_out=0x00001234, fwd_idx=5, mem_req never asserted.
- Signed byte load: addr=0x103, mem_rdata=0x80FF1234, mem_ack after 3 cycles → mem_addr=0x100; ld_pend=1 for 3 cycles; wb_out=0xFFFFFF80.
- Unsigned half load: addr=0x102, mem_rdata=0x80FF1234 → wb_out=0x000080FF. With DATA_L=64, a double load at 0x8 with rdata 0x8000000000000001 → wb_out=0x8000000000000001.
- Byte store: addr=0x101, data=0xAB → mem_we=1, mem_wdata=0x0000AB00, mem_wstrb=4'b0010, out_valid with wb_e=0.
- Misaligned word load at 0x102 → no mem_req; out_valid next cycle with exc_align=1 and wb_e=0.
- out_ready held 0 for 3 cycles → outputs stable and in_ready=0. Separately, rst during REQ → next cycle mem_req=0 with all outputs at reset values; a late mem_ack produces no out_valid.
